mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/utils_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/utils_pkg.sv
// Shared widths, memory access-width codes and arbiter state encoding.
package utils_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int INST_WIDTH = 32;

    // Memory access width codes; the U variants are zero-extending loads.
    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_D  = 3'd3,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5,
        MEM_WU = 3'd6
    } mem_wid_e;

    // Arbiter FSM: issue in IDLE, collect read data in WAIT.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

    // Which client owns the access currently in flight.
    typedef enum logic {
        PORT_LS = 1'b0,
        PORT_IF = 1'b1
    } arb_port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, load/store port and memory-side bus of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16
);
    import utils_pkg::*;

    // instruction fetch client
    logic                  if_req_valid_i;
    logic                  if_req_ready_o;
    logic [ADDR_W-1:0]     if_addr_i;
    logic                  if_resp_valid_o;
    logic                  if_resp_ready_i;
    logic [INST_WIDTH-1:0] if_inst_o;
    logic                  if_err_o;

    // load/store client
    logic                  ls_req_valid_i;
    logic                  ls_req_ready_o;
    logic [ADDR_W-1:0]     ls_addr_i;
    logic                  ls_we_i;
    logic [2:0]            ls_wid_i;
    logic [DATA_WIDTH-1:0] ls_wdata_i;
    logic                  ls_resp_valid_o;
    logic                  ls_resp_ready_i;
    logic [DATA_WIDTH-1:0] ls_rdata_o;
    logic                  ls_err_o;

    // memory side
    logic                  mem_en_o;
    logic                  mem_enwr_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [2:0]            mem_wid_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_unalign_i;

    // arbiter side
    modport slave (
        input  if_req_valid_i, if_addr_i, if_resp_ready_i,
        input  ls_req_valid_i, ls_addr_i, ls_we_i, ls_wid_i, ls_wdata_i, ls_resp_ready_i,
        input  mem_rdata_i, mem_unalign_i,
        output if_req_ready_o, if_resp_valid_o, if_inst_o, if_err_o,
        output ls_req_ready_o, ls_resp_valid_o, ls_rdata_o, ls_err_o,
        output mem_en_o, mem_enwr_o, mem_addr_o, mem_wid_o, mem_wdata_o
    );

    // clients + memory side
    modport master (
        output if_req_valid_i, if_addr_i, if_resp_ready_i,
        output ls_req_valid_i, ls_addr_i, ls_we_i, ls_wid_i, ls_wdata_i, ls_resp_ready_i,
        output mem_rdata_i, mem_unalign_i,
        input  if_req_ready_o, if_resp_valid_o, if_inst_o, if_err_o,
        input  ls_req_ready_o, ls_resp_valid_o, ls_rdata_o, ls_err_o,
        input  mem_en_o, mem_enwr_o, mem_addr_o, mem_wid_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and load/store with a fetch starvation guard.
module mem_arb_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_elig_i,   // fetch eligible this cycle
    input  logic ls_elig_i,   // load/store eligible this cycle
    input  logic if_pend_i,   // fetch request raised (eligible or not)
    output logic gnt_if_o,
    output logic gnt_ls_o
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starved;

    assign starved  = (starve_q == CNT_W'(STARVE_LIMIT));
    // Data port has priority until the fetch port has been passed over STARVE_LIMIT times.
    assign gnt_ls_o = ls_elig_i && !(if_elig_i && starved);
    assign gnt_if_o = if_elig_i && !gnt_ls_o;

    // Count data grants that bypass a waiting fetch; saturate, clear once fetch is served or gone.
    always_comb begin
        starve_d = starve_q;
        if (gnt_if_o || !if_pend_i)
            starve_d = '0;
        else if (gnt_ls_o && if_elig_i && !starved)
            starve_d = starve_q + CNT_W'(1);
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: one access per two cycles, response registers per client.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    import utils_pkg::*;

    arb_state_e            state_q, state_d;
    arb_port_e             port_q, port_d;
    logic                  we_q, we_d;
    logic                  unalign_q, unalign_d;

    logic                  if_resp_valid_q, if_resp_valid_d;
    logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;
    logic                  if_err_q, if_err_d;
    logic                  ls_resp_valid_q, ls_resp_valid_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
    logic                  ls_err_q, ls_err_d;

    logic                  if_elig, ls_elig, gnt_if, gnt_ls;
    logic                  if_misal, issue, in_wait;
    logic [ADDR_W-1:0]     if_addr, ls_addr;

    assign if_addr = bus.if_addr_i;
    assign ls_addr = bus.ls_addr_i;
    assign in_wait = (state_q == ST_WAIT);

    // A port may be granted only in IDLE and only if its response slot frees up this cycle.
    // rst_n gating keeps req_ready and mem_* low while reset is held.
    assign if_elig = rst_n && !in_wait && bus.if_req_valid_i &&
                     (!if_resp_valid_q || bus.if_resp_ready_i);
    assign ls_elig = rst_n && !in_wait && bus.ls_req_valid_i &&
                     (!ls_resp_valid_q || bus.ls_resp_ready_i);

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_elig_i (if_elig),
        .ls_elig_i (ls_elig),
        .if_pend_i (bus.if_req_valid_i),
        .gnt_if_o  (gnt_if),
        .gnt_ls_o  (gnt_ls)
    );

    // Misaligned fetches are answered locally without touching memory.
    assign if_misal = gnt_if && (if_addr[1:0] != 2'b00);
    assign issue    = gnt_ls || (gnt_if && !if_misal);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: a real memory access costs exactly one WAIT cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue) state_d = ST_WAIT;
            ST_WAIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake to the granted client and the memory command.
    always_comb begin
        bus.if_req_ready_o = gnt_if;
        bus.ls_req_ready_o = gnt_ls;
        bus.mem_en_o       = 1'b0;
        bus.mem_enwr_o     = 1'b0;
        bus.mem_addr_o     = '0;
        bus.mem_wid_o      = '0;
        bus.mem_wdata_o    = '0;
        if (gnt_ls) begin
            bus.mem_en_o    = 1'b1;
            bus.mem_enwr_o  = ~bus.ls_we_i;
            bus.mem_addr_o  = ls_addr;
            bus.mem_wid_o   = bus.ls_wid_i;
            bus.mem_wdata_o = bus.ls_wdata_i;
        end else if (gnt_if && !if_misal) begin
            bus.mem_en_o   = 1'b1;
            bus.mem_enwr_o = 1'b1;
            bus.mem_addr_o = if_addr;
            bus.mem_wid_o  = MEM_WU;
        end
    end

    // Capture owner, store flag and alignment fault on the issue edge.
    always_comb begin
        port_d    = port_q;
        we_d      = we_q;
        unalign_d = unalign_q;
        if (issue) begin
            port_d    = gnt_ls ? PORT_LS : PORT_IF;
            we_d      = gnt_ls && bus.ls_we_i;
            unalign_d = gnt_ls && bus.mem_unalign_i;
        end
    end

    // Response slots: clear on handshake, reload from memory in WAIT (same edge wins).
    always_comb begin
        if_resp_valid_d = if_resp_valid_q;
        if_inst_d       = if_inst_q;
        if_err_d        = if_err_q;
        ls_resp_valid_d = ls_resp_valid_q;
        ls_rdata_d      = ls_rdata_q;
        ls_err_d        = ls_err_q;

        if (if_resp_valid_q && bus.if_resp_ready_i) if_resp_valid_d = 1'b0;
        if (ls_resp_valid_q && bus.ls_resp_ready_i) ls_resp_valid_d = 1'b0;

        if (if_misal) begin
            if_resp_valid_d = 1'b1;
            if_inst_d       = '0;
            if_err_d        = 1'b1;
        end
        if (in_wait && port_q == PORT_IF) begin
            if_resp_valid_d = 1'b1;
            if_inst_d       = bus.mem_rdata_i[INST_WIDTH-1:0];
            if_err_d        = 1'b0;
        end
        if (in_wait && port_q == PORT_LS) begin
            ls_resp_valid_d = 1'b1;
            ls_rdata_d      = we_q ? '0 : bus.mem_rdata_i;  // store completes with zero data
            ls_err_d        = unalign_q;
        end
    end

    // Issue-side and response registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q          <= PORT_LS;
            we_q            <= 1'b0;
            unalign_q       <= 1'b0;
            if_resp_valid_q <= 1'b0;
            if_inst_q       <= '0;
            if_err_q        <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            ls_rdata_q      <= '0;
            ls_err_q        <= 1'b0;
        end else begin
            port_q          <= port_d;
            we_q            <= we_d;
            unalign_q       <= unalign_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_inst_q       <= if_inst_d;
            if_err_q        <= if_err_d;
            ls_resp_valid_q <= ls_resp_valid_d;
            ls_rdata_q      <= ls_rdata_d;
            ls_err_q        <= ls_err_d;
        end
    end

    assign bus.if_resp_valid_o = if_resp_valid_q;
    assign bus.if_inst_o       = if_inst_q;
    assign bus.if_err_o        = if_err_q;
    assign bus.ls_resp_valid_o = ls_resp_valid_q;
    assign bus.ls_rdata_o      = ls_rdata_q;
    assign bus.ls_err_o        = ls_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;
    import utils_pkg::*;

    localparam logic [63:0] W100 = 64'hCAFE_0000_0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic [63:0] mem_rdata = '0;

    mem_arbiter_if #(.ADDR_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [15:0] a);
        if (a == 16'h0010) return 64'h0000_0000_0000_0513;
        return 64'hCAFE_0000_0000_0000 | {48'h0, a};
    endfunction

    function automatic logic misal(input logic [15:0] a, input logic [2:0] w);
        case (w)
            MEM_H, MEM_HU: return a[0];
            MEM_W, MEM_WU: return a[1:0] != 2'b00;
            MEM_D:         return a[2:0] != 3'b000;
            default:       return 1'b0;
        endcase
    endfunction

    // memory: read data one cycle after the issue edge, alignment flag combinational
    always @(posedge clk)
        if (bus.mem_en_o && bus.mem_enwr_o) mem_rdata <= mem_word(bus.mem_addr_o);
    assign bus.mem_rdata_i   = mem_rdata;
    assign bus.mem_unalign_i = bus.mem_en_o && misal(bus.mem_addr_o, bus.mem_wid_o);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req_valid_i  = 1'b1;   // request during reset must not be accepted
        bus.if_addr_i       = 16'h0010;
        bus.if_resp_ready_i = 1'b1;
        bus.ls_req_valid_i  = 1'b0;
        bus.ls_addr_i       = '0;
        bus.ls_we_i         = 1'b0;
        bus.ls_wid_i        = '0;
        bus.ls_wdata_i      = '0;
        bus.ls_resp_ready_i = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_if_ready", bus.if_req_ready_o, 0);
        chk("rst_mem_en",   bus.mem_en_o, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_if_rv",    bus.if_resp_valid_o, 0);
        chk("rst_ls_rv",    bus.ls_resp_valid_o, 0);
        bus.if_req_valid_i = 1'b0;
        rst_n = 1'b1;

        // fetch 0x0010: issue at T, response at T+2
        cyc(); bus.if_req_valid_i = 1'b1; bus.if_addr_i = 16'h0010;
        @(negedge clk);
        chk("f_ready",   bus.if_req_ready_o, 1);
        chk("f_mem_en",  bus.mem_en_o, 1);
        chk("f_enwr",    bus.mem_enwr_o, 1);
        chk("f_addr",    bus.mem_addr_o, 16'h0010);
        chk("f_wid",     bus.mem_wid_o, MEM_WU);
        chk("f_ls_rdy",  bus.ls_req_ready_o, 0);
        cyc(); bus.if_req_valid_i = 1'b0;
        @(negedge clk);
        chk("f_t1_en",   bus.mem_en_o, 0);
        chk("f_t1_addr", bus.mem_addr_o, 0);
        chk("f_t1_rv",   bus.if_resp_valid_o, 0);
        cyc(); @(negedge clk);
        chk("f_t2_rv",   bus.if_resp_valid_o, 1);
        chk("f_t2_inst", bus.if_inst_o, 32'h0000_0513);
        chk("f_t2_err",  bus.if_err_o, 0);
        cyc(); @(negedge clk);
        chk("f_t3_rv",   bus.if_resp_valid_o, 0);

        // misaligned fetch 0x0006, then a load granted straight away (still IDLE)
        cyc(); bus.if_req_valid_i = 1'b1; bus.if_addr_i = 16'h0006;
        @(negedge clk);
        chk("mf_ready",  bus.if_req_ready_o, 1);
        chk("mf_mem_en", bus.mem_en_o, 0);
        cyc();
        bus.if_req_valid_i = 1'b0;
        bus.ls_req_valid_i = 1'b1; bus.ls_addr_i = 16'h0100; bus.ls_wid_i = MEM_D; bus.ls_we_i = 1'b0;
        @(negedge clk);
        chk("mf_rv",     bus.if_resp_valid_o, 1);
        chk("mf_err",    bus.if_err_o, 1);
        chk("mf_inst",   bus.if_inst_o, 0);
        chk("ld_ready",  bus.ls_req_ready_o, 1);
        chk("ld_enwr",   bus.mem_enwr_o, 1);
        cyc(); bus.ls_req_valid_i = 1'b0;
        @(negedge clk);
        chk("ld_t1_rv",  bus.ls_resp_valid_o, 0);
        cyc(); @(negedge clk);
        chk("ld_rv",     bus.ls_resp_valid_o, 1);
        chk("ld_rdata",  bus.ls_rdata_o, W100);
        chk("ld_err",    bus.ls_err_o, 0);

        // misaligned store word to 0x0102
        cyc();
        bus.ls_req_valid_i = 1'b1; bus.ls_addr_i = 16'h0102; bus.ls_wid_i = MEM_W;
        bus.ls_we_i = 1'b1; bus.ls_wdata_i = 64'h1122_3344_5566_7788;
        @(negedge clk);
        chk("st_en",     bus.mem_en_o, 1);
        chk("st_enwr",   bus.mem_enwr_o, 0);
        chk("st_wid",    bus.mem_wid_o, MEM_W);
        chk("st_wdata",  bus.mem_wdata_o, 64'h1122_3344_5566_7788);
        cyc(); bus.ls_req_valid_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_wdata_i = '0;
        cyc(); @(negedge clk);
        chk("st_rv",     bus.ls_resp_valid_o, 1);
        chk("st_err",    bus.ls_err_o, 1);
        chk("st_rdata",  bus.ls_rdata_o, 0);

        // fetch and load always valid: LS,LS,LS,LS,IF repeating on every other cycle
        cyc();
        bus.if_req_valid_i = 1'b1; bus.if_addr_i = 16'h0020;
        bus.ls_req_valid_i = 1'b1; bus.ls_addr_i = 16'h0100; bus.ls_wid_i = MEM_D;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k % 2 == 1)
                chk($sformatf("arb_wait%0d", k), {bus.if_req_ready_o, bus.ls_req_ready_o}, 2'b00);
            else if ((k / 2) % 5 == 4)
                chk($sformatf("arb_if%0d", k), {bus.if_req_ready_o, bus.ls_req_ready_o}, 2'b10);
            else
                chk($sformatf("arb_ls%0d", k), {bus.if_req_ready_o, bus.ls_req_ready_o}, 2'b01);
            cyc();
        end
        bus.if_req_valid_i = 1'b0; bus.ls_req_valid_i = 1'b0;
        repeat (3) cyc();

        // ls consumer stalls: response held, no LS grant, fetches still served
        bus.ls_resp_ready_i = 1'b0;
        bus.ls_req_valid_i = 1'b1; bus.ls_addr_i = 16'h0100; bus.ls_wid_i = MEM_D;
        @(negedge clk);
        chk("bp_ls_gnt", bus.ls_req_ready_o, 1);
        cyc(); cyc();
        bus.if_req_valid_i = 1'b1; bus.if_addr_i = 16'h0010;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("bp_rv%0d", k),    bus.ls_resp_valid_o, 1);
            chk($sformatf("bp_rd%0d", k),    bus.ls_rdata_o, W100);
            chk($sformatf("bp_lsrdy%0d", k), bus.ls_req_ready_o, 0);
            if (k % 2 == 0)
                chk($sformatf("bp_ifrdy%0d", k), bus.if_req_ready_o, 1);
            if (k == 4) begin
                chk("bp_if_rv",   bus.if_resp_valid_o, 1);
                chk("bp_if_inst", bus.if_inst_o, 32'h0000_0513);
            end
            cyc();
        end
        bus.ls_resp_ready_i = 1'b1; bus.if_req_valid_i = 1'b0;   // cycle 7 (WAIT)
        cyc();
        @(negedge clk);
        chk("bp_ls_regnt", bus.ls_req_ready_o, 1);
        cyc(); bus.ls_req_valid_i = 1'b0;
        repeat (3) cyc();

        // reset in WAIT: valids drop at once, the in-flight load never answers
        bus.if_resp_ready_i = 1'b0;
        bus.if_req_valid_i = 1'b1; bus.if_addr_i = 16'h0010;
        cyc(); bus.if_req_valid_i = 1'b0;
        cyc();
        bus.ls_req_valid_i = 1'b1; bus.ls_addr_i = 16'h0100; bus.ls_wid_i = MEM_D;
        @(negedge clk);
        chk("rw_if_rv", bus.if_resp_valid_o, 1);
        chk("rw_ls_gnt", bus.ls_req_ready_o, 1);
        cyc(); bus.ls_req_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rw_if_rv0", bus.if_resp_valid_o, 0);
        chk("rw_ls_rv0", bus.ls_resp_valid_o, 0);
        chk("rw_en0",    bus.mem_en_o, 0);
        bus.if_resp_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(); @(negedge clk);
            chk($sformatf("rw_post_ls%0d", k), bus.ls_resp_valid_o, 0);
            chk($sformatf("rw_post_if%0d", k), bus.if_resp_valid_o, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
